mem_load_store_unit: RTL and testbench

- Parametrised, sequential data-memory access unit for the CPU's MEM stage.
- Accepts one load or store request at a time from the pipeline and issues a word-aligned access to the data SRAM with per-byte write enables.
- Waits a variable number of cycles for the SRAM acknowledge, then returns lane-extracted, sign- or zero-extended load data, or a store acknowledge.
- Detects misalignment, illegal size and SRAM timeout, and returns each as an error code instead of data.

---
 rtl/mem_load_store_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store unit: one request at a time, word-aligned SRAM access
// with byte enables, lane extraction/extension and misalign/size/timeout errors.
module mem_load_store_unit #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_rvalid,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_err,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_SIZE  = 2'd3;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload stay stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state, state_d;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [7:0]      cnt_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      err_q;

    logic [1:0]      in_err;
    logic            misaligned;
    logic [OW-1:0]   off_q;
    logic [NB-1:0]   be_base;
    logic [DW-1:0]   wdata_rep;
    logic [DW-1:0]   rd_shift;
    logic [DW-1:0]   fmask;
    logic            sbit;
    logic [DW-1:0]   load_ext;
    logic            cnt_done;

    // Request decode: illegal size takes priority over alignment.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        in_err = ERR_OK;
        if (req_size == 2'd3 && DW == 32) in_err = ERR_SIZE;
        else if (misaligned)              in_err = ERR_ALIGN;
    end

    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = (in_err != ERR_OK) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                mem_en  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid || cnt_done) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 8'd0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= in_err;
                        rdata_q <= '0;
                    end
                end
                S_ISSUE: cnt_q <= 8'd0;
                S_WAIT: begin
                    // An acknowledge on the final counted cycle still counts as success.
                    if (mem_rvalid) begin
                        rdata_q <= we_q ? '0 : load_ext;
                        err_q   <= ERR_OK;
                    end else if (cnt_done) begin
                        rdata_q <= '0;
                        err_q   <= ERR_TMO;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign off_q = addr_q[OW-1:0];

    always_comb begin
        case (size_q)
            2'd0:    be_base = NB'(1);
            2'd1:    be_base = NB'(3);
            2'd2:    be_base = NB'(15);
            default: be_base = '1;
        endcase
        case (size_q)
            2'd0:    wdata_rep = {NB{wdata_q[7:0]}};
            2'd1:    wdata_rep = {(NB/2){wdata_q[15:0]}};
            2'd2:    wdata_rep = {(NB/4){wdata_q[31:0]}};
            default: wdata_rep = wdata_q;
        endcase
    end

    // Load path: shift the addressed lane down, keep its width, extend upward.
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    begin fmask = DW'(64'hFF);        sbit = rd_shift[7];  end
            2'd1:    begin fmask = DW'(64'hFFFF);      sbit = rd_shift[15]; end
            2'd2:    begin fmask = DW'(64'hFFFF_FFFF); sbit = rd_shift[31]; end
            default: begin fmask = '1;                 sbit = 1'b0;         end
        endcase
        load_ext = (rd_shift & fmask) | ((sbit && !uns_q) ? ~fmask : '0);
    end

    assign mem_addr  = (state == S_ISSUE) ? {addr_q[AW-1:OW], {OW{1'b0}}} : '0;
    assign mem_we    = (state == S_ISSUE && we_q) ? (be_base << off_q) : '0;
    assign mem_wdata = (state == S_ISSUE) ? wdata_rep : '0;
    assign rsp_rdata = (state == S_RESP) ? rdata_q : '0;
    assign rsp_err   = (state == S_RESP) ? err_q : ERR_OK;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Self-checking bench: a DW=32 (TIMEOUT_CYC=4) and a DW=64 (TIMEOUT_CYC=6) unit,
// directed cases then random transactions against an arithmetic reference model.
module tb_mem_load_store_unit;

    localparam int T_A = 4;
    localparam int T_B = 6;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        sel;
    logic        req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;
    logic        a_req_valid, b_req_valid, a_mem_rvalid, b_mem_rvalid;

    logic        a_req_ready, a_mem_en, a_rsp_valid, a_busy;
    logic [3:0]  a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_rsp_rdata;
    logic [1:0]  a_rsp_err, a_dbg_state;
    logic        b_req_ready, b_mem_en, b_rsp_valid, b_busy;
    logic [7:0]  b_mem_we;
    logic [31:0] b_mem_addr;
    logic [63:0] b_mem_wdata, b_rsp_rdata;
    logic [1:0]  b_rsp_err, b_dbg_state;

    mem_load_store_unit #(.DW(32), .AW(32), .TIMEOUT_CYC(T_A)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata[31:0]), .mem_rvalid(a_mem_rvalid),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy), .dbg_state(a_dbg_state)
    );

    mem_load_store_unit #(.DW(64), .AW(32), .TIMEOUT_CYC(T_B)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(b_mem_rvalid),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // view of the selected unit
    logic        o_req_ready, o_mem_en, o_rsp_valid, o_busy;
    logic [7:0]  o_mem_we;
    logic [31:0] o_mem_addr;
    logic [63:0] o_mem_wdata, o_rsp_rdata;
    logic [1:0]  o_rsp_err;
    always_comb begin
        o_req_ready = sel ? b_req_ready : a_req_ready;
        o_mem_en    = sel ? b_mem_en    : a_mem_en;
        o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
        o_busy      = sel ? b_busy      : a_busy;
        o_mem_we    = sel ? b_mem_we    : {4'd0, a_mem_we};
        o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
        o_mem_wdata = sel ? b_mem_wdata : {32'd0, a_mem_wdata};
        o_rsp_rdata = sel ? b_rsp_rdata : {32'd0, a_rsp_rdata};
        o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    end

    // scoreboard: expected response data of the current transaction
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model, straight from the access rules
    task automatic model(input int dw, input bit we, input int size, input bit uns,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata,
                         output logic [1:0] e_err, output logic [31:0] e_addr,
                         output logic [7:0] e_be, output logic [63:0] e_wd,
                         output logic [63:0] e_rd);
        int nb, bytes, off;
        logic [63:0] dmask, fmask, field;
        nb    = dw / 8;
        bytes = 1 << size;
        off   = int'(addr % nb);
        dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        fmask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * bytes)) - 64'd1;
        if (size == 3 && dw == 32)   e_err = 2'd3;
        else if (addr % bytes != 0)  e_err = 2'd1;
        else                         e_err = 2'd0;
        e_addr = addr - (addr % nb);
        e_be   = we ? 8'(((1 << bytes) - 1) << off) : 8'd0;
        field  = wdata & fmask;
        e_wd   = 64'd0;
        for (int k = 0; k < nb / bytes; k++) e_wd = e_wd | (field << (8 * bytes * k));
        e_wd  = e_wd & dmask;
        field = (rdata >> (8 * off)) & fmask;
        if (!uns && bytes * 8 < dw && field[8 * bytes - 1])
            field = field - (64'd1 << (8 * bytes));
        e_rd = we ? 64'd0 : (field & dmask);
    endtask

    // driver: one full transaction; lat = WAIT cycle of the ack (>= timeout: none)
    task automatic txn(input bit s, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int lat, input int hold);
        logic [1:0]  e_err;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wd, e_rd, exp_rd;
        int t, n, exp_n;
        t = s ? T_B : T_A;
        model(s ? 64 : 32, we, int'(size), uns, addr, wdata, rdata, e_err, e_addr, e_be, e_wd, e_rd);
        sel = s; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        if (s) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        chk("req_ready_idle", o_req_ready, 1);
        @(posedge clk); @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        if (e_err != 2'd0) begin
            chk("early_mem_en", o_mem_en, 0);
            exp_q.push_back(64'd0);
        end else begin
            chk("issue_mem_en", o_mem_en, 1);
            chk("issue_addr", o_mem_addr, e_addr);
            chk("issue_we", o_mem_we, e_be);
            chk("issue_wdata", o_mem_wdata, e_wd);
            chk("issue_ready", o_req_ready, 0);
            @(posedge clk); @(negedge clk);
            n = 0;
            forever begin
                if (n == 0) chk("wait_mem_en", o_mem_en, 0);
                mem_rdata = (n == lat) ? rdata : {$urandom, $urandom};
                if (n == lat) begin
                    if (s) b_mem_rvalid = 1'b1; else a_mem_rvalid = 1'b1;
                end
                @(posedge clk); @(negedge clk);
                a_mem_rvalid = 1'b0; b_mem_rvalid = 1'b0;
                if (o_rsp_valid) break;
                n++;
                if (n > 40) break;
            end
            exp_n = (lat < t) ? lat : t - 1;
            chk("wait_cycles", 64'(n), 64'(exp_n));
            if (lat >= t) e_err = 2'd2;
            exp_q.push_back((lat < t) ? e_rd : 64'd0);
        end
        exp_rd = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", o_rsp_valid, 1);
            chk("rsp_err", o_rsp_err, e_err);
            chk("rsp_rdata", o_rsp_rdata, exp_rd);
            chk("rsp_req_ready", o_req_ready, 0);
            chk("rsp_busy", o_busy, 1);
            if (h < hold) begin @(posedge clk); @(negedge clk); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_rsp_valid", o_rsp_valid, 0);
        chk("done_req_ready", o_req_ready, 1);
        chk("done_busy", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        bit          s;
        rst = 1'b1; sel = 1'b0;
        a_req_valid = 0; b_req_valid = 0; a_mem_rvalid = 0; b_mem_rvalid = 0;
        req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        mem_rdata = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_mem_en", b_mem_en, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_rdata", b_rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        txn(0, 0, 2'd0, 0, 32'h1003, 64'h0, 64'h80AA_BBCC, 0, 0);
        txn(0, 0, 2'd0, 1, 32'h1003, 64'h0, 64'h80AA_BBCC, 0, 0);
        txn(0, 1, 2'd1, 0, 32'h2002, 64'h1234, 64'h0, 1, 0);
        txn(0, 0, 2'd2, 0, 32'h3001, 64'h0, 64'h0, 0, 0);
        txn(0, 0, 2'd2, 0, 32'h4000, 64'h0, 64'h0, T_A, 3);
        txn(0, 0, 2'd1, 0, 32'h4006, 64'h0, 64'h8001_7FFF, T_A - 1, 0);
        txn(0, 0, 2'd3, 0, 32'h0010, 64'h0, 64'h0, 0, 1);
        txn(1, 0, 2'd3, 0, 32'h0008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 0);
        txn(1, 0, 2'd1, 1, 32'h000E, 64'h0, 64'hBEEF_0000_0000_0000, 0, 0);
        txn(1, 0, 2'd2, 0, 32'h0024, 64'h0, 64'h9000_0000_1111_1111, 1, 0);
        txn(1, 1, 2'd0, 0, 32'h0005, 64'hA5, 64'h0, 0, 0);
        txn(1, 0, 2'd3, 0, 32'h0104, 64'h0, 64'h0, 0, 0);
        txn(1, 1, 2'd2, 0, 32'h0040, 64'h0, 64'h0, T_B, 1);

        // reset while waiting, then a stale acknowledge
        sel = 1'b0; req_we = 0; req_size = 2'd2; req_addr = 32'h100; a_req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        a_req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_req_ready", a_req_ready, 1);
        chk("arst_busy", a_busy, 0);
        chk("arst_state", a_dbg_state, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); a_mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF;
        @(posedge clk); @(negedge clk); a_mem_rvalid = 1'b0;
        chk("late_ack_rsp_valid", a_rsp_valid, 0);
        chk("late_ack_req_ready", a_req_ready, 1);
        chk("late_ack_busy", a_busy, 0);
        chk("late_ack_mem_en", a_mem_en, 0);

        // random transactions
        for (int i = 0; i < 60; i++) begin
            s  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ad = $urandom & 32'hFFFF;
            if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            txn(s, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, s ? T_B : T_A), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
